// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Programmable timer sequencer built around a free-running counter. It has a
//   prescaler, a compare match, one-shot or periodic operation and a sticky
//   level interrupt with an overflow flag. Software programs it through a
//   write-only register port and reads it back through a combinational port.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   cfg_valid  register write strobe, accepted in the same cycle
//   cfg_addr   write address: 0=CTRL 1=COMPARE 2=PRESCALE 3=reserved
//   cfg_wdata  write data (CTRL: [0] start, [1] stop, [2] periodic mode)
//   rd_addr    read address: 0=STATUS 1=COMPARE 2=PRESCALE 3=COUNT
//   rd_data    combinational read data, zero-extended
//   irq_ack    clears irq and ovf
//   count      current timer count
//   running    high while the FSM is in RUN
//   irq        level interrupt, held until irq_ack
//
// State | meaning
//   IDLE  | stopped, count holds
//   RUN   | prescaler and count advancing
//   DONE  | one-shot match reached, count holds 0
module timer_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    input  logic [1:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [PS_WIDTH-1:0] prescaler;
    logic [PS_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]    compare;
    logic                periodic;
    logic                ovf;

    logic ctrl_wr;
    logic start_cmd;
    logic stop_cmd;
    logic tick;
    logic match;

    // Stop beats start in the same write; any CTRL command beats the tick.
    always_comb begin
        ctrl_wr   = cfg_valid && (cfg_addr == 2'd0);
        stop_cmd  = ctrl_wr && cfg_wdata[1];
        start_cmd = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
        tick      = (state == RUN) && (prescaler == prescale) && !start_cmd && !stop_cmd;
        match     = tick && (count == compare);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            running   <= 1'b0;
            count     <= '0;
            prescaler <= '0;
            compare   <= '1;
            prescale  <= '0;
            periodic  <= 1'b0;
            irq       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (cfg_valid) begin
                case (cfg_addr)
                    2'd1:    compare  <= cfg_wdata;
                    2'd2:    prescale <= PS_WIDTH'(cfg_wdata);
                    default: ;
                endcase
            end

            // The match below still uses the mode that was in force before this write.
            if (ctrl_wr) begin
                periodic <= cfg_wdata[2];
            end

            if (stop_cmd) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (start_cmd) begin
                state     <= RUN;
                running   <= 1'b1;
                count     <= '0;
                prescaler <= '0;
            end else if (state == RUN) begin
                if (tick) begin
                    prescaler <= '0;
                    if (match) begin
                        count <= '0;
                        if (!periodic) begin
                            state   <= DONE;
                            running <= 1'b0;
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    prescaler <= prescaler + PS_WIDTH'(1);
                end
            end

            // A match sets irq even when acknowledged; the ack still clears ovf.
            if (match) begin
                irq <= 1'b1;
                if (irq_ack) begin
                    ovf <= 1'b0;
                end else if (irq) begin
                    ovf <= 1'b1;
                end
            end else if (irq_ack) begin
                irq <= 1'b0;
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            2'd0:    rd_data = WIDTH'({ovf, irq, (state == DONE), running});
            2'd1:    rd_data = compare;
            2'd2:    rd_data = WIDTH'(prescale);
            default: rd_data = count;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       irq_ack = 1'b0;
    logic [7:0] count;
    logic       running;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    timer_ctrl #(.WIDTH(8), .PS_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .irq_ack   (irq_ack),
        .count     (count),
        .running   (running),
        .irq       (irq)
    );

    initial forever #5 clk = ~clk;

    // Reference model: integers and flags describing the timer's observable behaviour.
    int m_count, m_ps, m_cmp, m_pre;
    bit m_run, m_done, m_periodic, m_irq, m_ovf;

    task automatic model_reset();
        m_count = 0; m_ps = 0; m_cmp = 255; m_pre = 0;
        m_run = 0; m_done = 0; m_periodic = 0; m_irq = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit wr_ctrl, start, stop, tk, mt;
        wr_ctrl = cfg_valid && (cfg_addr == 2'd0);
        stop    = wr_ctrl && cfg_wdata[1];
        start   = wr_ctrl && cfg_wdata[0] && !stop;
        tk      = m_run && !start && !stop && (m_ps == m_pre);
        mt      = tk && (m_count == m_cmp);
        if (mt) begin
            if (irq_ack) m_ovf = 0;
            else if (m_irq) m_ovf = 1;
            m_irq = 1;
        end else if (irq_ack) begin
            m_irq = 0;
            m_ovf = 0;
        end
        if (stop) begin
            m_run = 0; m_done = 0;
        end else if (start) begin
            m_run = 1; m_done = 0; m_count = 0; m_ps = 0;
        end else if (m_run) begin
            if (tk) begin
                m_ps = 0;
                if (mt) begin
                    m_count = 0;
                    if (!m_periodic) begin
                        m_run = 0; m_done = 1;
                    end
                end else begin
                    m_count = (m_count + 1) % 256;
                end
            end else begin
                m_ps = (m_ps + 1) % 256;
            end
        end
        if (wr_ctrl) m_periodic = cfg_wdata[2];
        if (cfg_valid && cfg_addr == 2'd1) m_cmp = int'(cfg_wdata);
        if (cfg_valid && cfg_addr == 2'd2) m_pre = int'(cfg_wdata);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [1:0] save;
        save = rd_addr;
        check({tag, ".count"},   32'(count),   32'(m_count));
        check({tag, ".running"}, 32'(running), 32'(m_run));
        check({tag, ".irq"},     32'(irq),     32'(m_irq));
        rd_addr = 2'd0; #1;
        check({tag, ".status"},  32'(rd_data), 32'({m_ovf, m_irq, m_done, m_run}));
        rd_addr = 2'd1; #1;
        check({tag, ".compare"}, 32'(rd_data), 32'(m_cmp));
        rd_addr = 2'd2; #1;
        check({tag, ".prescale"}, 32'(rd_data), 32'(m_pre));
        rd_addr = 2'd3; #1;
        check({tag, ".rd_count"}, 32'(rd_data), 32'(m_count));
        rd_addr = save;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_wdata = d;
        step("write");
        cfg_valid = 1'b0;
    endtask

    task automatic ack_cycle();
        irq_ack = 1'b1;
        step("ack");
        irq_ack = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] v);
        rd_addr = 2'd0; #1;
        v = rd_data;
    endtask

    initial begin
        logic [7:0] st;
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        // Reset state
        check("rst.count", 32'(count), 0);
        check("rst.running", 32'(running), 0);
        check("rst.irq", 32'(irq), 0);
        rd_addr = 2'd1; #1;
        check("rst.compare", 32'(rd_data), 32'hFF);
        rd_addr = 2'd2; #1;
        check("rst.prescale", 32'(rd_data), 0);
        read_status(st);
        check("rst.status", 32'(st), 0);

        // 1: periodic, PRESCALE=0, COMPARE=3
        write_reg(2'd1, 8'd3);
        write_reg(2'd2, 8'd0);
        write_reg(2'd0, 8'd5);
        check("t1.start_count", 32'(count), 0);
        check("t1.start_running", 32'(running), 1);
        for (int i = 1; i <= 3; i++) begin
            step("t1.run");
            check("t1.count_seq", 32'(count), 32'(i));
            check("t1.irq_low", 32'(irq), 0);
        end
        step("t1.match");
        check("t1.match_count", 32'(count), 0);
        check("t1.irq_rise", 32'(irq), 1);
        ack_cycle();
        check("t1.ack_irq", 32'(irq), 0);
        step("t1.run2");
        step("t1.run3");
        check("t1.before_rematch", 32'(irq), 0);
        step("t1.rematch");
        check("t1.rematch_irq", 32'(irq), 1);
        check("t1.rematch_count", 32'(count), 0);

        // 2: one-shot, PRESCALE=2, COMPARE=1
        write_reg(2'd0, 8'd2);
        ack_cycle();
        write_reg(2'd2, 8'd2);
        write_reg(2'd1, 8'd1);
        write_reg(2'd0, 8'd1);
        for (int i = 1; i <= 5; i++) begin
            step("t2.run");
            check("t2.irq_low", 32'(irq), 0);
            check("t2.running", 32'(running), 1);
        end
        step("t2.match");
        check("t2.irq", 32'(irq), 1);
        check("t2.running_off", 32'(running), 0);
        read_status(st);
        check("t2.status_done", 32'(st), 32'h6);
        repeat (3) step("t2.hold");
        check("t2.count_hold", 32'(count), 0);
        read_status(st);
        check("t2.status_hold", 32'(st), 32'h6);

        // 3: periodic COMPARE=0, overflow then ack on a match
        ack_cycle();
        write_reg(2'd1, 8'd0);
        write_reg(2'd2, 8'd0);
        write_reg(2'd0, 8'd5);
        step("t3.m1");
        read_status(st);
        check("t3.status_first", 32'(st), 32'h5);
        step("t3.m2");
        read_status(st);
        check("t3.status_ovf", 32'(st), 32'hD);
        ack_cycle();
        read_status(st);
        check("t3.status_ack_on_match", 32'(st), 32'h5);
        write_reg(2'd0, 8'd2);
        read_status(st);
        check("t3.status_stopped", 32'(st), 32'h4);

        // 4: start and stop together while IDLE
        ack_cycle();
        write_reg(2'd1, 8'd255);
        write_reg(2'd0, 8'd1);
        repeat (5) step("t4.run");
        write_reg(2'd0, 8'd2);
        check("t4.stop_count", 32'(count), 5);
        write_reg(2'd0, 8'd3);
        check("t4.both_running", 32'(running), 0);
        check("t4.both_count", 32'(count), 5);
        read_status(st);
        check("t4.both_status", 32'(st), 0);

        // 5: lower COMPARE below count while running -> wrap before match
        write_reg(2'd2, 8'd0);
        write_reg(2'd1, 8'd255);
        write_reg(2'd0, 8'd5);
        repeat (200) step("t5.run");
        check("t5.count200", 32'(count), 200);
        write_reg(2'd1, 8'd10);
        check("t5.count201", 32'(count), 201);
        n = 0;
        while (irq !== 1'b1 && n < 300) begin
            step("t5.wrap");
            n++;
        end
        check("t5.cycles_to_match", 32'(n), 66);
        check("t5.match_count", 32'(count), 0);
        check("t5.irq", 32'(irq), 1);

        // 6: asynchronous reset mid-run with irq high
        step("t6.pre");
        check("t6.pre_irq", 32'(irq), 1);
        check("t6.pre_running", 32'(running), 1);
        #1 reset = 1'b1;
        #1;
        check("t6.irq_async", 32'(irq), 0);
        check("t6.count_async", 32'(count), 0);
        check("t6.running_async", 32'(running), 0);
        rd_addr = 2'd1; #1;
        check("t6.compare_async", 32'(rd_data), 32'hFF);
        reset = 1'b0;
        model_reset();
        step("t6.post");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            if (cfg_addr == 2'd1 || cfg_addr == 2'd2) begin
                d = 8'($urandom_range(0, 5));
            end else begin
                d = 8'($urandom_range(0, 7));
                if (d[1] && $urandom_range(0, 2) != 0) d[1] = 1'b0;
            end
            cfg_wdata = d;
            irq_ack   = ($urandom_range(0, 7) == 0);
            rd_addr   = 2'($urandom_range(0, 3));
            step("rand");
        end
        cfg_valid = 1'b0;
        irq_ack   = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
